// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, RV32I opcode constants and the decoded-bundle type.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [FUNC_W-1:0] {
    FC_NONE  = 4'd0,
    FC_ADD   = 4'd1,
    FC_SUB   = 4'd2,
    FC_SHL_U = 4'd3,
    FC_SHR_U = 4'd4,
    FC_SHL_S = 4'd5,
    FC_SHR_S = 4'd6,
    FC_LT    = 4'd7,
    FC_EQ    = 4'd8,
    FC_NEQ   = 4'd9,
    FC_AND   = 4'd10,
    FC_OR    = 4'd11,
    FC_XOR   = 4'd12,
    FC_NOR   = 4'd13
  } func_code_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    func_code_e        func_code;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic              is_branch;
    logic              illegal;
  } dec_bundle_t;

  // funct3 mapping shared by register and immediate arithmetic forms (f7 = base)
  function automatic func_code_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return FC_ADD;
      3'b001:  return FC_SHL_U;
      3'b010:  return FC_LT;
      3'b011:  return FC_LT;
      3'b100:  return FC_XOR;
      3'b101:  return FC_SHR_U;
      3'b110:  return FC_OR;
      default: return FC_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder_if.sv
// Valid/ready instruction-in / decoded-bundle-out bus of the ALU decoder.
interface alu_decoder_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [FUNC_W-1:0]    func_code;
  logic [REG_W-1:0]     rs1;
  logic [REG_W-1:0]     rs2;
  logic [REG_W-1:0]     rd;
  logic [XLEN-1:0]      imm;
  logic                 use_imm;
  logic                 is_branch;
  logic                 illegal;
  logic [CNT_W-1:0]     illegal_cnt;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, func_code, rs1, rs2, rd, imm,
           use_imm, is_branch, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, func_code, rs1, rs2, rd, imm,
           use_imm, is_branch, illegal, illegal_cnt
  );

endinterface

// File: rtl/alu_dec_comb.sv
// Combinational RV32I -> ALU bundle decode; unsupported encodings yield a zeroed illegal bundle.
module alu_dec_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_bundle_t     dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign shamt  = {27'd0, instr[24:20]};

  logic            legal;
  func_code_e      fc;
  logic            use_imm;
  logic            is_branch;
  logic [XLEN-1:0] imm;

  always_comb begin
    legal     = 1'b1;
    fc        = FC_NONE;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE)                           fc = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)   fc = FC_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)   fc = FC_SHR_S;
        else                                             legal = 1'b0;
      end
      OPC_I: begin
        use_imm = 1'b1;
        // shift forms carry funct7 in the upper immediate bits
        if (funct3 == 3'b001) begin
          imm = shamt;
          if (funct7 == F7_BASE) fc = FC_SHL_U;
          else                   legal = 1'b0;
        end else if (funct3 == 3'b101) begin
          imm = shamt;
          if (funct7 == F7_BASE)     fc = FC_SHR_U;
          else if (funct7 == F7_ALT) fc = FC_SHR_S;
          else                       legal = 1'b0;
        end else begin
          imm = i_imm;
          fc  = base_op(funct3);
        end
      end
      OPC_B: begin
        is_branch = 1'b1;
        imm       = b_imm;
        case (funct3)
          3'b000:         fc = FC_EQ;
          3'b001:         fc = FC_NEQ;
          3'b100, 3'b110: fc = FC_LT;
          default:        legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        fc      = FC_ADD;
        use_imm = 1'b1;
        imm     = i_imm;
      end
      OPC_STORE: begin
        fc      = FC_ADD;
        use_imm = 1'b1;
        imm     = s_imm;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    if (legal) begin
      dec.func_code = fc;
      dec.imm       = imm;
      dec.use_imm   = use_imm;
      dec.is_branch = is_branch;
    end else begin
      dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decoder.sv
// Registered ALU decoder with one-entry skid buffer and optional illegal-bundle
// counter (enabled by defining ALU_DEC_ILLEGAL_CNT_EN).
module alu_decoder
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_decoder_if.slave bus
);

  dec_bundle_t dec_c;
  dec_bundle_t out_q, out_d;
  dec_bundle_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q;
  logic        accept_c;
  logic        out_free_c;

  alu_dec_comb u_dec_comb (
    .instr (bus.instr),
    .dec   (dec_c)
  );

  assign accept_c   = bus.in_valid && in_ready_q;
  assign out_free_c = !out_valid_q || bus.out_ready;

  // Output stage refills from skid first so order is preserved
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free_c) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        out_d        = dec_c;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

`ifdef ALU_DEC_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q;

  // Saturating count of illegal bundles handed to the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && out_q.illegal
                 && illegal_cnt_q != {CNT_W{1'b1}}) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign bus.illegal_cnt = illegal_cnt_q;
`else
  assign bus.illegal_cnt = '0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.func_code = out_q.func_code;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.rd        = out_q.rd;
  assign bus.imm       = out_q.imm;
  assign bus.use_imm   = out_q.use_imm;
  assign bus.is_branch = out_q.is_branch;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases plus randomized traffic
// against a queue-based reference model of the decode rules and buffering.
module tb_alu_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_decoder_if ifc ();

  alu_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    int          fc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    bit          ui;
    bit          br;
    bit          il;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_m  = 0;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode computed from the instruction-set rules with plain arithmetic
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   arith [8];
    int   op, f3, f7, im;
    arith = '{1, 3, 7, 7, 12, 4, 11, 10};
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.fc = 0; e.ui = 0; e.br = 0; e.il = 0; im = 0;
    if (op == 'h33) begin
      if (f7 == 0)                  e.fc = arith[f3];
      else if (f7 == 32 && f3 == 0) e.fc = 2;
      else if (f7 == 32 && f3 == 5) e.fc = 6;
    end else if (op == 'h13) begin
      e.ui = 1;
      if (f3 == 1) begin
        im = int'(w[24:20]);
        e.fc = (f7 == 0) ? 3 : 0;
      end else if (f3 == 5) begin
        im = int'(w[24:20]);
        e.fc = (f7 == 0) ? 4 : (f7 == 32) ? 6 : 0;
      end else begin
        im = int'($signed(w) >>> 20);
        e.fc = arith[f3];
      end
    end else if (op == 'h63) begin
      e.br = 1;
      im = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      if (f3 == 0)                e.fc = 8;
      else if (f3 == 1)           e.fc = 9;
      else if (f3 == 4 || f3 == 6) e.fc = 7;
    end else if (op == 'h03) begin
      e.ui = 1; e.fc = 1;
      im = int'($signed(w) >>> 20);
    end else if (op == 'h23) begin
      e.ui = 1; e.fc = 1;
      im = int'($signed(w) >>> 25) * 32 + int'(w[11:7]);
    end
    e.imm = 32'(im);
    if (e.fc == 0) begin
      e.il = 1; e.ui = 0; e.br = 0; e.imm = '0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [5];
    int          k;
    ops = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23};
    w = $urandom;
    k = int'($urandom_range(0, 5));
    if (k < 5) w[6:0] = ops[k];
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    int exp_cnt;
    exp_cnt = CNT_EN ? cnt_m : 0;
    check("out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(ifc.in_ready), 32'(q.size() < 2));
    check("illegal_cnt", 32'(ifc.illegal_cnt), 32'(exp_cnt));
    if (q.size() > 0) begin
      check("func_code", 32'(ifc.func_code), 32'(q[0].fc));
      check("imm", ifc.imm, q[0].imm);
      check("rs1", 32'(ifc.rs1), 32'(q[0].rs1));
      check("rs2", 32'(ifc.rs2), 32'(q[0].rs2));
      check("rd", 32'(ifc.rd), 32'(q[0].rd));
      check("use_imm", 32'(ifc.use_imm), 32'(q[0].ui));
      check("is_branch", 32'(ifc.is_branch), 32'(q[0].br));
      check("illegal", 32'(ifc.illegal), 32'(q[0].il));
    end
  endtask

  // One clock: check at negedge, predict transfers, update model at posedge
  task automatic tick();
    bit fi, fo;
    @(negedge clk);
    check_outputs();
    fi = ifc.in_valid && (q.size() < 2);
    fo = (q.size() > 0) && ifc.out_ready;
    @(posedge clk);
    if (fo) begin
      if (q[0].il && cnt_m < 65535) cnt_m++;
      void'(q.pop_front());
    end
    if (fi) q.push_back(ref_decode(ifc.instr));
    #1;
  endtask

  task automatic offer(input logic [31:0] w);
    ifc.in_valid = 1'b1;
    ifc.instr    = w;
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.instr     = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_func_code", 32'(ifc.func_code), 32'd0);
    check("rst_imm", ifc.imm, 32'd0);
    check("rst_flags", 32'({ifc.use_imm, ifc.is_branch, ifc.illegal}), 32'd0);
    check("rst_illegal_cnt", 32'(ifc.illegal_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // sub x2,x1,x2
    ifc.out_ready = 1'b1;
    offer(32'h40208133);
    tick();
    check("sub_valid", 32'(ifc.out_valid), 32'd1);
    check("sub_fc", 32'(ifc.func_code), 32'd2);
    check("sub_rd", 32'(ifc.rd), 32'd2);
    check("sub_rs1", 32'(ifc.rs1), 32'd1);
    check("sub_rs2", 32'(ifc.rs2), 32'd2);
    check("sub_use_imm", 32'(ifc.use_imm), 32'd0);

    // slti imm -1 followed back-to-back by srai x1,x1,3
    offer(32'hFFF0A093);
    tick();
    check("slti_fc", 32'(ifc.func_code), 32'd7);
    check("slti_imm", ifc.imm, 32'hFFFFFFFF);
    offer(32'h4030D093);
    tick();
    check("srai_valid", 32'(ifc.out_valid), 32'd1);
    check("srai_fc", 32'(ifc.func_code), 32'd6);
    check("srai_imm", ifc.imm, 32'd3);

    // bne x1,x2,+8
    offer(32'h00209463);
    tick();
    check("bne_fc", 32'(ifc.func_code), 32'd9);
    check("bne_branch", 32'(ifc.is_branch), 32'd1);
    check("bne_imm", ifc.imm, 32'd8);
    ifc.in_valid = 1'b0;
    tick();

    // backpressure: three words offered while stalled, only two fit
    ifc.out_ready = 1'b0;
    offer(32'h002081B3);
    tick();
    offer(32'h00A30293);
    tick();
    offer(32'h00412023);
    tick();
    check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    check("bp_head_fc", 32'(ifc.func_code), 32'd1);
    check("bp_head_rd", 32'(ifc.rd), 32'd3);
    tick();
    ifc.out_ready = 1'b1;
    tick();
    check("bp_second_rd", 32'(ifc.rd), 32'd5);
    tick();
    ifc.in_valid = 1'b0;
    check("bp_third_imm", ifc.imm, 32'd0);
    check("bp_third_use_imm", 32'(ifc.use_imm), 32'd1);
    repeat (2) tick();

    // three illegal words
    offer(32'hFFFFFFFF);
    repeat (3) begin
      tick();
      check("ill_flag", 32'(ifc.illegal), 32'd1);
      check("ill_fc", 32'(ifc.func_code), 32'd0);
    end
    ifc.in_valid = 1'b0;
    repeat (2) tick();
    check("ill_cnt", 32'(ifc.illegal_cnt), CNT_EN ? 32'd3 : 32'd0);

    // reset while two bundles are buffered
    ifc.out_ready = 1'b0;
    offer(32'hFFFFFFFF);
    repeat (2) tick();
    ifc.in_valid = 1'b0;
    check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_cnt", 32'(ifc.illegal_cnt), 32'd0);
    q.delete();
    cnt_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // randomized traffic with random backpressure
    repeat (500) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      ifc.instr     = rand_instr();
      tick();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
